// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator with trap/jump redirect, stall and halt/resume
// Optional feature macro: PC_GEN_MISALIGN_CHK_EN (reject jumps whose target is not INC_BYTES-aligned)
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            trap_flag_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            valid_o,
  output logic            halted_o,
  output logic            misalign_o
);

  localparam int              INC_SHIFT = $clog2(INC_BYTES);
  localparam logic [XLEN-1:0] INC       = XLEN'(INC_BYTES);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            valid;
  logic            valid_next;
  logic            jump_bad;
  logic            jump_take;

`ifdef PC_GEN_MISALIGN_CHK_EN
  logic misalign;

  assign jump_bad = jump_flag_i && (jump_addr_i[INC_SHIFT-1:0] != '0);

  // one-cycle pulse for every rejected (misaligned) jump request
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= jump_bad;
  end

  assign misalign_o = misalign;
`else
  assign jump_bad   = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // a rejected jump behaves exactly as if no jump had been requested
  assign jump_take = jump_flag_i && !jump_bad;

  // next-state / next-pc: trap > jump > halt > stall > increment in RUN; HALT leaves only on redirect or resume
  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = valid;
    if (rst) begin
      state_next = RUN;
      pc_next    = RESET_VEC;
      valid_next = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (trap_flag_i) begin
            pc_next    = trap_vec_i;
            valid_next = 1'b1;
          end else if (jump_take) begin
            pc_next    = jump_addr_i;
            valid_next = 1'b1;
          end else if (halt_i) begin
            state_next = HALT;
            valid_next = 1'b0;
          end else if (stall_i) begin
            valid_next = 1'b1;
          end else begin
            pc_next    = pc + INC;
            valid_next = 1'b1;
          end
        end
        HALT: begin
          if (trap_flag_i) begin
            pc_next    = trap_vec_i;
            state_next = RUN;
            valid_next = 1'b1;
          end else if (jump_take) begin
            pc_next    = jump_addr_i;
            state_next = RUN;
            valid_next = 1'b1;
          end else if (resume_i) begin
            pc_next    = pc + INC;
            state_next = RUN;
            valid_next = 1'b1;
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // state register; reset dominates everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_VEC;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      valid <= valid_next;
    end
  end

  assign pc_o      = pc;
  assign pc_next_o = pc_next;
  assign valid_o   = valid;
  assign halted_o  = (state == HALT);

endmodule
